instruction_fetch_unit: RTL

//  Upstream producer of the instruction word and OPCODE that the control unit decodes.

---
 rtl/cpu_defs_pkg.sv | 27 ++
 rtl/ifu_pc_next.sv | 29 ++
 rtl/instruction_fetch_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, fetch FSM encoding.
package cpu_defs;

  localparam logic [7:0] OPC_ADD   = 8'h00;
  localparam logic [7:0] OPC_SUB   = 8'h01;
  localparam logic [7:0] OPC_AND   = 8'h02;
  localparam logic [7:0] OPC_OR    = 8'h03;
  localparam logic [7:0] OPC_MOV   = 8'h04;
  localparam logic [7:0] OPC_LOADI = 8'h05;
  localparam logic [7:0] OPC_J     = 8'h06;
  localparam logic [7:0] OPC_BEQ   = 8'h07;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 24;
  localparam int OFFSET_MSB = 23;
  localparam int OFFSET_LSB = 16;

  // Opcode 8'hFF never decodes, so downstream sees a harmless word after reset.
  localparam logic [31:0] RESET_INSTRUCTION = 32'hFF00_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10
  } ifu_state_t;

endpackage

// File: rtl/ifu_pc_next.sv
// Next-PC selection: sequential step or PC-relative target (word offset, sign-extended).
module ifu_pc_next #(
  parameter int PC_WIDTH = 32,
  parameter int PC_STEP  = 4
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [7:0]          offset,
  input  logic                branch,
  input  logic                jump,
  input  logic                zero,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] tgt_pc;
  logic [PC_WIDTH-1:0] offset_bytes;

  assign offset_bytes = {{(PC_WIDTH-8){offset[7]}}, offset} << 2;
  assign seq_pc       = pc + PC_WIDTH'(PC_STEP);
  assign tgt_pc       = seq_pc + offset_bytes;

  always_comb begin
    next_pc = seq_pc;
    if (jump || (branch && zero)) begin
      next_pc = tgt_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: holds PC, handshakes with instruction memory, presents one
// instruction per execute slot and then advances PC.
module instruction_fetch_unit
  import cpu_defs::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  PC_STEP     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_read,
  output logic [PC_WIDTH-1:0]    imem_address,
  input  logic [INSTR_WIDTH-1:0] imem_readdata,
  input  logic                   imem_busywait,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [7:0]             opcode,
  output logic                   instr_valid,
  output logic [PC_WIDTH-1:0]    pc,
  input  logic                   branch,
  input  logic                   jump,
  input  logic                   zero
);

  ifu_state_t          state;
  ifu_state_t          state_next;
  logic                in_exec;
  logic [PC_WIDTH-1:0] pc_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: if (!imem_busywait) state_next = S_EXEC;
      S_EXEC:  state_next = S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    imem_read   = 1'b0;
    instr_valid = 1'b0;
    case (state)
      S_FETCH: imem_read   = 1'b1;
      S_EXEC:  instr_valid = 1'b1;
      default: ;
    endcase
  end

  assign in_exec      = (state == S_EXEC);
  assign imem_address = pc;
  assign opcode       = instruction[OPCODE_MSB:OPCODE_LSB];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (in_exec) begin
      pc <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruction <= INSTR_WIDTH'(RESET_INSTRUCTION);
    end else if ((state == S_FETCH) && !imem_busywait) begin
      instruction <= imem_readdata;
    end
  end

  // Control inputs are masked outside the execute slot so X there cannot reach the PC.
  ifu_pc_next #(
    .PC_WIDTH (PC_WIDTH),
    .PC_STEP  (PC_STEP)
  ) u_pc_next (
    .pc      (pc),
    .offset  (instruction[OFFSET_MSB:OFFSET_LSB]),
    .branch  (branch & in_exec),
    .jump    (jump & in_exec),
    .zero    (zero & in_exec),
    .next_pc (pc_next)
  );

endmodule
